// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: direct-mapped single-word-per-line I-cache with a
// multi-beat memory refill path and saturating hit/miss counters.
module instr_fetch_unit #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MEMWIDTH = 8,
    parameter int unsigned LINES    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch,
    input  logic [WIDTH-1:0]    pc,
    input  logic                flush,
    input  logic [MEMWIDTH-1:0] memdata,
    input  logic                memvalid,
    output logic                memread,
    output logic [WIDTH-1:0]    memadr,
    output logic [31:0]         instr,
    output logic                valid,
    output logic                hit,
    output logic                busy,
    output logic [15:0]         hitcount,
    output logic [15:0]         misscount
);

    localparam int unsigned IDXBITS   = $clog2(LINES);
    localparam int unsigned TAGBITS   = WIDTH - 2 - IDXBITS;
    localparam int unsigned BEATS     = 32 / MEMWIDTH;
    localparam int unsigned BEATBITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BYTES     = MEMWIDTH / 8;
    localparam int unsigned LAST_BEAT = BEATS - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEATBITS-1:0] beat_q, beat_d;
    logic [WIDTH-1:0]    base_q, base_d;
    logic [31:0]         instr_q, instr_d;
    logic                hit_q, hit_d;
    logic [15:0]         hitcnt_q, hitcnt_d;
    logic [15:0]         misscnt_q, misscnt_d;
    logic                memread_q, memread_d;
    logic [WIDTH-1:0]    memadr_q, memadr_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic [LINES-1:0]    line_vld_q;
    logic [TAGBITS-1:0]  line_tag_q  [LINES];
    logic [31:0]         line_data_q [LINES];

    logic [IDXBITS-1:0]  rd_idx;
    logic [TAGBITS-1:0]  rd_tag;
    logic [IDXBITS-1:0]  wr_idx;
    logic [TAGBITS-1:0]  wr_tag;
    logic                lookup_hit;
    logic                wr_en;
    logic                unused_pc;

    // Byte offset within the word is meaningless for a 32-bit fetch.
    assign unused_pc = ^pc[1:0];

    assign rd_idx     = pc[2 +: IDXBITS];
    assign rd_tag     = pc[WIDTH-1 -: TAGBITS];
    assign wr_idx     = base_q[2 +: IDXBITS];
    assign wr_tag     = base_q[WIDTH-1 -: TAGBITS];
    assign lookup_hit = line_vld_q[rd_idx] && (line_tag_q[rd_idx] == rd_tag);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        instr_d   = instr_q;
        hit_d     = hit_q;
        hitcnt_d  = hitcnt_q;
        misscnt_d = misscnt_q;
        wr_en     = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
            beat_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch) begin
                        if (lookup_hit) begin
                            instr_d  = line_data_q[rd_idx];
                            hit_d    = 1'b1;
                            hitcnt_d = (hitcnt_q == 16'hFFFF) ? hitcnt_q : hitcnt_q + 16'd1;
                            state_d  = S_DONE;
                        end else begin
                            base_d    = {pc[WIDTH-1:2], 2'b00};
                            beat_d    = '0;
                            misscnt_d = (misscnt_q == 16'hFFFF) ? misscnt_q : misscnt_q + 16'd1;
                            state_d   = S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (memvalid) begin
                        for (int unsigned b = 0; b < BEATS; b++) begin
                            if (beat_q == BEATBITS'(b)) begin
                                instr_d[b*MEMWIDTH +: MEMWIDTH] = memdata;
                            end
                        end
                        if (beat_q == BEATBITS'(LAST_BEAT)) begin
                            wr_en   = 1'b1;
                            hit_d   = 1'b0;
                            beat_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            beat_d = BEATBITS'(beat_q + 1'b1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        memread_d = (state_d == S_FILL);
        memadr_d  = memread_d ? WIDTH'(base_d + WIDTH'(beat_d) * WIDTH'(BYTES)) : '0;
        valid_d   = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            instr_q   <= '0;
            hit_q     <= 1'b0;
            hitcnt_q  <= '0;
            misscnt_q <= '0;
            memread_q <= 1'b0;
            memadr_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            instr_q   <= instr_d;
            hit_q     <= hit_d;
            hitcnt_q  <= hitcnt_d;
            misscnt_q <= misscnt_d;
            memread_q <= memread_d;
            memadr_q  <= memadr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Line valid bits: reset and flush clear every line in a single cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            line_vld_q <= '0;
        end else if (wr_en) begin
            line_vld_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; they are only meaningful under a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            line_tag_q[wr_idx]  <= wr_tag;
            line_data_q[wr_idx] <= instr_d;
        end
    end

    assign memread   = memread_q;
    assign memadr    = memadr_q;
    assign instr     = instr_q;
    assign valid     = valid_q;
    assign hit       = hit_q;
    assign busy      = busy_q;
    assign hitcount  = hitcnt_q;
    assign misscount = misscnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: byte-wide default instance plus a
// 32-bit memory bus instance.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        fetch_a, flush_a, memvalid_a;
    logic [7:0]  pc_a, memdata_a;
    logic        memread_a, valid_a, hit_a, busy_a;
    logic [7:0]  memadr_a;
    logic [31:0] instr_a;
    logic [15:0] hitcnt_a, misscnt_a;

    logic        fetch_b, flush_b, memvalid_b;
    logic [7:0]  pc_b;
    logic [31:0] memdata_b;
    logic        memread_b, valid_b, hit_b, busy_b;
    logic [7:0]  memadr_b;
    logic [31:0] instr_b;
    logic [15:0] hitcnt_b, misscnt_b;

    instr_fetch_unit dut_a (
        .clk(clk), .reset(reset), .fetch(fetch_a), .pc(pc_a), .flush(flush_a),
        .memdata(memdata_a), .memvalid(memvalid_a), .memread(memread_a),
        .memadr(memadr_a), .instr(instr_a), .valid(valid_a), .hit(hit_a),
        .busy(busy_a), .hitcount(hitcnt_a), .misscount(misscnt_a)
    );

    instr_fetch_unit #(.WIDTH(8), .MEMWIDTH(32), .LINES(16)) dut_b (
        .clk(clk), .reset(reset), .fetch(fetch_b), .pc(pc_b), .flush(flush_b),
        .memdata(memdata_b), .memvalid(memvalid_b), .memread(memread_b),
        .memadr(memadr_b), .instr(instr_b), .valid(valid_b), .hit(hit_b),
        .busy(busy_b), .hitcount(hitcnt_b), .misscount(misscnt_b)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic        hit;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset && valid_a) begin
            if (q_a.size() == 0) begin
                chk_cnt++;
                $display("FAIL a_unexpected_valid: got valid with instr 0x%0h, expected none", instr_a);
            end else begin
                e = q_a.pop_front();
                check("a_instr", instr_a, e.instr);
                check("a_hit", {31'b0, hit_a}, {31'b0, e.hit});
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!reset && valid_b) begin
            if (q_b.size() == 0) begin
                chk_cnt++;
                $display("FAIL b_unexpected_valid: got valid with instr 0x%0h, expected none", instr_b);
            end else begin
                e = q_b.pop_front();
                check("b_instr", instr_b, e.instr);
                check("b_hit", {31'b0, hit_b}, {31'b0, e.hit});
            end
        end
    end

    task automatic miss_a(input logic [7:0] p, input logic [31:0] word, input int gap);
        q_a.push_back('{instr: word, hit: 1'b0});
        fetch_a = 1'b1;
        pc_a    = p;
        tick();
        fetch_a = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                for (int g = 0; g < gap; g++) begin
                    check("a_gap_memadr", {24'b0, memadr_a}, {24'b0, 8'(p + b)});
                    check("a_gap_memread", {31'b0, memread_a}, 32'd1);
                    tick();
                end
            end
            check("a_memadr", {24'b0, memadr_a}, {24'b0, 8'(p + b)});
            check("a_memread", {31'b0, memread_a}, 32'd1);
            memvalid_a = 1'b1;
            memdata_a  = word[b*8 +: 8];
            tick();
            memvalid_a = 1'b0;
        end
        check("a_done_busy", {31'b0, busy_a}, 32'd1);
        check("a_done_memread", {31'b0, memread_a}, 32'd0);
        tick();
        check("a_idle_busy", {31'b0, busy_a}, 32'd0);
    endtask

    task automatic hit_a_t(input logic [7:0] p, input logic [31:0] word);
        q_a.push_back('{instr: word, hit: 1'b1});
        fetch_a = 1'b1;
        pc_a    = p;
        tick();
        fetch_a = 1'b0;
        check("a_hit_valid_latency", {31'b0, valid_a}, 32'd1);
        check("a_hit_memread", {31'b0, memread_a}, 32'd0);
        tick();
        check("a_hit_idle_memread", {31'b0, memread_a}, 32'd0);
        check("a_hit_idle_busy", {31'b0, busy_a}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        fetch_a = 1'b0; flush_a = 1'b0; memvalid_a = 1'b0; pc_a = '0; memdata_a = '0;
        fetch_b = 1'b0; flush_b = 1'b0; memvalid_b = 1'b0; pc_b = '0; memdata_b = '0;
        tick();
        tick();
        check("rst_instr", instr_a, 32'h0);
        check("rst_valid", {31'b0, valid_a}, 32'd0);
        check("rst_hit", {31'b0, hit_a}, 32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_memread", {31'b0, memread_a}, 32'd0);
        check("rst_memadr", {24'b0, memadr_a}, 32'd0);
        check("rst_hitcount", {16'b0, hitcnt_a}, 32'd0);
        check("rst_misscount", {16'b0, misscnt_a}, 32'd0);
        reset = 1'b0;
        tick();

        // Cold miss then hit on the same line.
        miss_a(8'h10, 32'h12345678, 0);
        check("miss1_count", {16'b0, misscnt_a}, 32'd1);
        hit_a_t(8'h10, 32'h12345678);
        check("hit1_count", {16'b0, hitcnt_a}, 32'd1);

        // 0x50 aliases index 4 with a different tag, evicting 0x10.
        miss_a(8'h50, 32'hAABBCCDD, 0);
        miss_a(8'h10, 32'h12345678, 3);
        check("miss3_count", {16'b0, misscnt_a}, 32'd3);

        // Abort a fill after two beats.
        fetch_a = 1'b1;
        pc_a    = 8'h30;
        tick();
        fetch_a = 1'b0;
        memvalid_a = 1'b1; memdata_a = 8'h11; tick();
        memdata_a = 8'h22; tick();
        memvalid_a = 1'b0;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        check("flush_memread", {31'b0, memread_a}, 32'd0);
        check("flush_busy", {31'b0, busy_a}, 32'd0);
        check("flush_memadr", {24'b0, memadr_a}, 32'd0);
        check("flush_partial_instr", instr_a, 32'h12342211);
        check("flush_misscount", {16'b0, misscnt_a}, 32'd4);
        tick();

        miss_a(8'h30, 32'h04030201, 0);
        check("refetch_misscount", {16'b0, misscnt_a}, 32'd5);

        // Flush together with fetch in IDLE: fetch dropped, cache emptied.
        fetch_a = 1'b1; flush_a = 1'b1; pc_a = 8'h30;
        tick();
        fetch_a = 1'b0; flush_a = 1'b0;
        check("ff_busy", {31'b0, busy_a}, 32'd0);
        check("ff_memread", {31'b0, memread_a}, 32'd0);
        check("ff_hitcount", {16'b0, hitcnt_a}, 32'd1);
        check("ff_misscount", {16'b0, misscnt_a}, 32'd5);
        tick();
        miss_a(8'h30, 32'h04030201, 1);
        check("post_flush_misscount", {16'b0, misscnt_a}, 32'd6);
        hit_a_t(8'h30, 32'h04030201);
        check("final_hitcount", {16'b0, hitcnt_a}, 32'd2);

        // 32-bit memory bus: single-beat fill, then hit.
        q_b.push_back('{instr: 32'hDEADBEEF, hit: 1'b0});
        fetch_b = 1'b1;
        pc_b    = 8'h20;
        tick();
        fetch_b = 1'b0;
        check("b_memadr", {24'b0, memadr_b}, 32'h20);
        check("b_memread", {31'b0, memread_b}, 32'd1);
        memvalid_b = 1'b1;
        memdata_b  = 32'hDEADBEEF;
        tick();
        memvalid_b = 1'b0;
        check("b_valid", {31'b0, valid_b}, 32'd1);
        check("b_done_memread", {31'b0, memread_b}, 32'd0);
        tick();
        q_b.push_back('{instr: 32'hDEADBEEF, hit: 1'b1});
        fetch_b = 1'b1;
        tick();
        fetch_b = 1'b0;
        check("b_hit_valid", {31'b0, valid_b}, 32'd1);
        check("b_hit_memread", {31'b0, memread_b}, 32'd0);
        tick();
        check("b_misscount", {16'b0, misscnt_b}, 32'd1);
        check("b_hitcount", {16'b0, hitcnt_b}, 32'd1);

        tick();
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 8, address width in bits; SHALL be at least IDXBITS+3.
REQ-002 Parameter MEMWIDTH, default 8, memory data bus width; SHALL be one of 8, 16 or 32.
REQ-003 Parameter LINES, default 16, number of instruction cache lines; SHALL be a power of 2. IDXBITS = log2(LINES).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fetch  in  1  fetch request; sampled only in IDLE.
REQ-007 pc  in  WIDTH  byte address of the instruction; pc[1:0] ignored, treated as 0.
REQ-008 flush  in  1  invalidate the whole cache and abort any fill in progress.
REQ-009 memdata  in  MEMWIDTH  memory read data.
REQ-010 memvalid  in  1  memdata valid for the current beat.
REQ-011 memread  out  1  beat read request.
REQ-012 memadr  out  WIDTH  beat byte address.
REQ-013 instr  out  32  last completed instruction.
REQ-014 valid  out  1  one-cycle pulse when instr updates.
REQ-015 hit  out  1  source of the last completed instr: 1 = cache, 0 = memory.
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 hitcount, misscount  out  16 each  saturating event counters.

Function
REQ-018 BEATS = 32/MEMWIDTH; index = pc[2 +: IDXBITS]; tag = pc[WIDTH-1 : 2+IDXBITS].
REQ-019 Cache: direct-mapped; each line holds a valid bit, a tag and a 32-bit word.
REQ-020 FSM states: IDLE, FILL, DONE.
REQ-021 IDLE, fetch=1, flush=0, lookup hit: instr <= line word, hit <= 1, hitcount +1, next state DONE.
REQ-022 IDLE, fetch=1, flush=0, lookup miss: latch word-aligned pc, beat counter <= 0, misscount +1, next state FILL.
REQ-023 FILL: memread=1 and memadr = latched pc + beat*(MEMWIDTH/8), modulo 2^WIDTH.
REQ-024 FILL, memvalid=1: instr[beat*MEMWIDTH +: MEMWIDTH] <= memdata (beat 0 = least-significant bits), then beat +1.
REQ-025 FILL, memvalid=0: hold beat, memadr and memread; no stall limit.
REQ-026 FILL, memvalid on last beat: write the line (valid=1, tag, assembled word), hit <= 0, next state DONE.
REQ-027 The cache write uses the word completed on the same edge, so the written word includes the last beat.
REQ-028 DONE: valid=1 for exactly this cycle, then next state IDLE; fetch is ignored in DONE.
REQ-029 Latency on a hit: fetch accepted at edge N, valid high in the cycle after edge N; memread never asserted.
REQ-030 Latency on a miss: valid high in the cycle after the edge that accepts the last memvalid.
REQ-031 memread=0 and memadr=0 in IDLE and DONE.
REQ-032 Outside a hit or a fill completion, instr and hit hold their values.
REQ-033 flush, in any state: all line valid bits cleared in one cycle, next state IDLE, no valid pulse, no cache write.
REQ-034 flush in FILL: beats already merged into instr remain; a later refetch overwrites them.
REQ-035 flush=1 together with fetch=1 in IDLE: flush wins; the fetch is dropped and no counter changes.
REQ-036 Counters stop at 16'hFFFF; flush does not clear them.

Reset
REQ-037 On reset: state IDLE, all line valid bits 0, instr=0, valid=0, hit=0, busy=0, memread=0, memadr=0, hitcount=0, misscount=0, beat=0.
REQ-038 Reset takes priority over flush and fetch, and aborts a fill in progress with no cache write.

Verification
REQ-039 Defaults. Reset; fetch pc=0x10; memdata 0x78, 0x56, 0x34, 0x12 with memvalid -> memadr 0x10, 0x11, 0x12, 0x13; instr=0x12345678; valid pulse; hit=0; misscount=1.
REQ-040 Then fetch pc=0x10 -> valid in the next cycle, hit=1, instr=0x12345678, memread stays 0, hitcount=1.
REQ-041 Then fetch 0x50 (index 4, new tag) -> miss, fill of 0xAABBCCDD; then fetch 0x10 -> miss, misscount=3.
REQ-042 Fill with memvalid gaps of 3 cycles between beats -> memadr holds across each gap; correct word; valid only after the 4th beat.
REQ-043 flush after 2 beats of a fill -> memread=0 in the next cycle, no valid pulse, busy=0; refetch of the same pc misses.
REQ-044 MEMWIDTH=32 instance: fetch 0x20 miss, single memvalid with 0xDEADBEEF -> instr=0xDEADBEEF after 1 beat; refetch hits.
